// File: rtl/blur_kernel_scheduler_pkg.sv
// Shared types and helpers for the blur kernel scheduler: kernel codes,
// scheduler FSM states and the kernel radius lookup.
package blur_pkg;

  localparam int unsigned FLAG_W = 3;

  typedef enum logic [FLAG_W-1:0] {
    K1 = 3'b000,
    K3 = 3'b001,
    K5 = 3'b010
  } kernel_t;

  typedef enum logic {
    RUN   = 1'b0,
    PRIME = 1'b1
  } sched_state_t;

  // Line-buffer radius of each kernel; a 1x1 kernel needs no re-priming.
  function automatic logic [1:0] kernel_radius(kernel_t k);
    case (k)
      K3:      return 2'd1;
      K5:      return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/blur_kernel_scheduler_if.sv
// Pixel-stream handshake, kernel request and status bundle of the blur kernel
// scheduler; master = stream/control source, slave = scheduler.
interface blur_kernel_scheduler_if;
  import blur_pkg::*;

  logic              req_valid;
  logic [FLAG_W-1:0] req_flag;
  logic              in_valid;
  logic              in_sop;
  logic              in_eop;
  logic              out_ready;
  logic              in_ready;
  logic              out_valid;
  logic [FLAG_W-1:0] freq_flag;
  logic              priming;
  logic              change_pulse;
  logic              frame_err;
  logic [15:0]       frame_count;
  logic [15:0]       change_count;

  modport master (
    output req_valid, req_flag, in_valid, in_sop, in_eop, out_ready,
    input  in_ready, out_valid, freq_flag, priming, change_pulse, frame_err,
           frame_count, change_count
  );

  modport slave (
    input  req_valid, req_flag, in_valid, in_sop, in_eop, out_ready,
    output in_ready, out_valid, freq_flag, priming, change_pulse, frame_err,
           frame_count, change_count
  );

endinterface

// File: rtl/blur_kernel_scheduler_frame_pos_counter.sv
// Tracks the (x, y) position of accepted pixels within a frame, resyncing on
// sop/eop; flags a misplaced sop and reports whether this pixel is the last.
module frame_pos_counter #(
  parameter int unsigned IMG_WIDTH  = 320,
  parameter int unsigned IMG_HEIGHT = 240
) (
  input  logic clk,
  input  logic reset,
  input  logic i_acc,
  input  logic i_sop,
  input  logic i_eop,
  output logic o_last_pixel,
  output logic o_err
);

  localparam int unsigned XW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int unsigned YW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  logic [XW-1:0] r_x, w_x_eff, w_x_nxt;
  logic [YW-1:0] r_y, w_y_eff, w_y_nxt;

  // An sop pixel is always treated as (0,0), whatever the counters held.
  assign w_x_eff      = i_sop ? '0 : r_x;
  assign w_y_eff      = i_sop ? '0 : r_y;
  assign o_last_pixel = (w_x_eff == XW'(IMG_WIDTH - 1)) &&
                        (w_y_eff == YW'(IMG_HEIGHT - 1));
  assign o_err        = i_acc && i_sop && ((r_x != '0) || (r_y != '0));

  always_comb begin
    w_x_nxt = r_x;
    w_y_nxt = r_y;
    if (i_acc) begin
      if (i_eop) begin
        w_x_nxt = '0;
        w_y_nxt = '0;
      end else if (w_x_eff == XW'(IMG_WIDTH - 1)) begin
        w_x_nxt = '0;
        w_y_nxt = w_y_eff + YW'(1);
      end else begin
        w_x_nxt = w_x_eff + XW'(1);
        w_y_nxt = w_y_eff;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_x <= '0;
      r_y <= '0;
    end else begin
      r_x <= w_x_nxt;
      r_y <= w_y_nxt;
    end
  end

endmodule

// File: rtl/blur_kernel_scheduler.sv
// Commits kernel-size requests to freq_flag at frame boundaries with a minimum
// dwell, then masks out_valid while the filter line buffers re-prime.
// Optional statistics counters: define BLUR_SCHED_STATS_EN.
module blur_kernel_scheduler
  import blur_pkg::*;
#(
  parameter int unsigned       IMG_WIDTH    = 320,
  parameter int unsigned       IMG_HEIGHT   = 240,
  parameter int unsigned       DWELL_FRAMES = 2,
  parameter logic [FLAG_W-1:0] MAX_FLAG     = 3'b010
) (
  input  logic                    clk,
  input  logic                    reset,
  blur_kernel_scheduler_if.slave  bus
);

  localparam int unsigned PW = $clog2(2 * IMG_WIDTH + 3);
  localparam int unsigned DW = 4;

  logic          w_acc;
  logic          w_boundary;
  logic          w_change;
  logic          w_last_pixel;
  logic          w_sop_err;
  logic [1:0]    w_radius;
  logic [PW-1:0] w_prime_load;
  logic [PW-1:0] w_prime_nxt;
  kernel_t       w_req_kernel;
  sched_state_t  w_state_nxt;

  sched_state_t  r_state;
  logic [PW-1:0] r_prime_cnt;
  kernel_t       r_freq_flag;
  kernel_t       r_pending;
  logic [DW-1:0] r_dwell;
  logic          r_change_pulse;
  logic          r_frame_err;

  assign w_acc      = bus.in_valid & bus.out_ready;
  assign w_boundary = w_acc & bus.in_eop;

  // Compared against the registered pending value, so a request landing on
  // the eop cycle only becomes eligible at the following boundary.
  assign w_change = w_boundary && (r_pending != r_freq_flag) &&
                    (r_dwell >= DW'(DWELL_FRAMES));

  assign w_req_kernel = (bus.req_flag > MAX_FLAG) ? kernel_t'(MAX_FLAG)
                                                  : kernel_t'(bus.req_flag);
  assign w_radius     = kernel_radius(r_pending);
  assign w_prime_load = PW'(w_radius) * PW'(IMG_WIDTH) + PW'(w_radius);

  frame_pos_counter #(
    .IMG_WIDTH  (IMG_WIDTH),
    .IMG_HEIGHT (IMG_HEIGHT)
  ) u_pos (
    .clk          (clk),
    .reset        (reset),
    .i_acc        (w_acc),
    .i_sop        (bus.in_sop),
    .i_eop        (bus.in_eop),
    .o_last_pixel (w_last_pixel),
    .o_err        (w_sop_err)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_prime_nxt = r_prime_cnt;
    if (w_change) begin
      w_prime_nxt = w_prime_load;
      w_state_nxt = (w_prime_load == '0) ? RUN : PRIME;
    end else if ((r_state == PRIME) && w_acc) begin
      w_prime_nxt = r_prime_cnt - PW'(1);
      if (r_prime_cnt == PW'(1)) begin
        w_state_nxt = RUN;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= RUN;
      r_prime_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_prime_cnt <= w_prime_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_freq_flag    <= K1;
      r_pending      <= K1;
      r_dwell        <= DW'(DWELL_FRAMES);
      r_change_pulse <= 1'b0;
      r_frame_err    <= 1'b0;
    end else begin
      r_change_pulse <= w_change;
      if (bus.req_valid) begin
        r_pending <= w_req_kernel;
      end
      if (w_boundary) begin
        if (w_change) begin
          r_freq_flag <= r_pending;
          r_dwell     <= '0;
        end else if (r_dwell < DW'(DWELL_FRAMES)) begin
          r_dwell <= r_dwell + DW'(1);
        end
      end
      if (w_sop_err || (w_boundary && !w_last_pixel)) begin
        r_frame_err <= 1'b1;
      end
    end
  end

  assign bus.in_ready     = bus.out_ready;
  assign bus.out_valid    = bus.in_valid & (r_state != PRIME);
  assign bus.priming      = (r_state == PRIME);
  assign bus.freq_flag    = r_freq_flag;
  assign bus.change_pulse = r_change_pulse;
  assign bus.frame_err    = r_frame_err;

`ifdef BLUR_SCHED_STATS_EN
  logic [15:0] r_frame_count;
  logic [15:0] r_change_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_frame_count  <= '0;
      r_change_count <= '0;
    end else begin
      if (w_boundary) begin
        r_frame_count <= r_frame_count + 16'd1;
      end
      if (r_change_pulse) begin
        r_change_count <= r_change_count + 16'd1;
      end
    end
  end

  assign bus.frame_count  = r_frame_count;
  assign bus.change_count = r_change_count;
`else
  assign bus.frame_count  = '0;
  assign bus.change_count = '0;
`endif

endmodule

// File: tb/tb_blur_kernel_scheduler.sv
// Directed, table-driven bench for blur_kernel_scheduler on a 15x15 frame
// with a two-frame dwell.
module tb_blur_kernel_scheduler;
  import blur_pkg::*;

  localparam int unsigned W = 15;
  localparam int unsigned H = 15;
  localparam int          FPIX = W * H;
  localparam int          NFV = 22;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  blur_kernel_scheduler_if bus();

  blur_kernel_scheduler #(
    .IMG_WIDTH    (W),
    .IMG_HEIGHT   (H),
    .DWELL_FRAMES (2),
    .MAX_FLAG     (3'b010)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_err    = 0;
  logic [2:0] cur_flag;

  typedef struct {
    bit         req_en;
    int         req_pix;
    logic [2:0] req_flag;
    int         len;
    bit         bp;
    int         exp_mask;
    logic [2:0] exp_flag;
    bit         exp_pulse;
    bit         exp_err;
  } frame_vec_t;

  typedef struct {
    logic in_valid;
    logic out_ready;
    logic exp_in_ready;
    logic exp_out_valid;
  } comb_vec_t;

  frame_vec_t fv[NFV];
  comb_vec_t  cv[4];
  frame_vec_t post_rst;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    bus.in_valid  = 1'b0;
    bus.in_sop    = 1'b0;
    bus.in_eop    = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_flag  = 3'b000;
    bus.out_ready = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    cur_flag = 3'b000;
  endtask

  task automatic run_frame(input frame_vec_t v, input string tag);
    int masked;
    masked = 0;
    for (int p = 0; p < v.len; p++) begin
      if (v.bp && p == 5) begin
        for (int c = 0; c < 10; c++) begin
          @(negedge clk);
          bus.in_valid  = 1'b1;
          bus.in_sop    = 1'b0;
          bus.in_eop    = 1'b0;
          bus.req_valid = 1'b0;
          bus.out_ready = 1'b0;
          #1;
          check({tag, " bp_in_ready"}, bus.in_ready, 1'b0);
          check({tag, " bp_priming"}, bus.priming, 1'b1);
          check({tag, " bp_out_valid"}, bus.out_valid, 1'b0);
        end
      end
      @(negedge clk);
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_sop    = (p == 0);
      bus.in_eop    = (p == v.len - 1);
      bus.req_valid = v.req_en && (p == v.req_pix);
      bus.req_flag  = v.req_flag;
      #1;
      if (!bus.out_valid) masked++;
      if (p == v.len - 1) check({tag, " flag_hold"}, bus.freq_flag, cur_flag);
    end
    @(negedge clk);
    idle();
    #1;
    check({tag, " masked"}, masked, v.exp_mask);
    check({tag, " freq_flag"}, bus.freq_flag, v.exp_flag);
    check({tag, " change_pulse"}, bus.change_pulse, v.exp_pulse);
    check({tag, " frame_err"}, bus.frame_err, v.exp_err);
    @(negedge clk);
    #1;
    if (v.exp_pulse) check({tag, " pulse_width"}, bus.change_pulse, 1'b0);
    cur_flag = v.exp_flag;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // req_en, req_pix, req_flag, len, bp, exp_mask, exp_flag, exp_pulse, exp_err
    fv[0]  = '{1'b1,  50, 3'd2, FPIX, 1'b0,  0, 3'd2, 1'b1, 1'b0};
    fv[1]  = '{1'b1,   0, 3'd1, FPIX, 1'b0, 32, 3'd2, 1'b0, 1'b0};
    fv[2]  = '{1'b0,   0, 3'd0, FPIX, 1'b0,  0, 3'd2, 1'b0, 1'b0};
    fv[3]  = '{1'b0,   0, 3'd0, FPIX, 1'b0,  0, 3'd1, 1'b1, 1'b0};
    fv[4]  = '{1'b0,   0, 3'd0, FPIX, 1'b0, 16, 3'd1, 1'b0, 1'b0};
    fv[5]  = '{1'b0,   0, 3'd0, FPIX, 1'b0,  0, 3'd1, 1'b0, 1'b0};
    fv[6]  = '{1'b1,  50, 3'd0, FPIX, 1'b0,  0, 3'd0, 1'b1, 1'b0};
    fv[7]  = '{1'b0,   0, 3'd0, FPIX, 1'b0,  0, 3'd0, 1'b0, 1'b0};
    fv[8]  = '{1'b0,   0, 3'd0, FPIX, 1'b0,  0, 3'd0, 1'b0, 1'b0};
    fv[9]  = '{1'b1,  50, 3'd7, FPIX, 1'b0,  0, 3'd2, 1'b1, 1'b0};
    fv[10] = '{1'b0,   0, 3'd0, FPIX, 1'b0, 32, 3'd2, 1'b0, 1'b0};
    fv[11] = '{1'b0,   0, 3'd0, FPIX, 1'b0,  0, 3'd2, 1'b0, 1'b0};
    fv[12] = '{1'b1,  50, 3'd7, FPIX, 1'b0,  0, 3'd2, 1'b0, 1'b0};
    fv[13] = '{1'b1, 224, 3'd1, FPIX, 1'b0,  0, 3'd2, 1'b0, 1'b0};
    fv[14] = '{1'b0,   0, 3'd0, FPIX, 1'b0,  0, 3'd1, 1'b1, 1'b0};
    fv[15] = '{1'b0,   0, 3'd0, FPIX, 1'b0, 16, 3'd1, 1'b0, 1'b0};
    fv[16] = '{1'b0,   0, 3'd0, FPIX, 1'b0,  0, 3'd1, 1'b0, 1'b0};
    fv[17] = '{1'b1,  50, 3'd2, FPIX, 1'b0,  0, 3'd2, 1'b1, 1'b0};
    fv[18] = '{1'b0,   0, 3'd0, FPIX, 1'b1, 32, 3'd2, 1'b0, 1'b0};
    fv[19] = '{1'b0,   0, 3'd0, FPIX, 1'b0,  0, 3'd2, 1'b0, 1'b0};
    fv[20] = '{1'b1,  50, 3'd1,  101, 1'b0,  0, 3'd1, 1'b1, 1'b1};
    fv[21] = '{1'b0,   0, 3'd0, FPIX, 1'b0, 16, 3'd1, 1'b0, 1'b1};
    post_rst = '{1'b1, 50, 3'd1, FPIX, 1'b0, 0, 3'd1, 1'b1, 1'b0};

    cv[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
    cv[1] = '{1'b1, 1'b0, 1'b0, 1'b1};
    cv[2] = '{1'b0, 1'b1, 1'b1, 1'b0};
    cv[3] = '{1'b1, 1'b1, 1'b1, 1'b1};

    idle();
    reset = 1'b1;
    cur_flag = 3'b000;
    do_reset();
    #1;
    check("rst freq_flag", bus.freq_flag, 3'b000);
    check("rst priming", bus.priming, 1'b0);
    check("rst frame_err", bus.frame_err, 1'b0);
    check("rst change_pulse", bus.change_pulse, 1'b0);
    check("rst frame_count", bus.frame_count, 16'd0);
    check("rst change_count", bus.change_count, 16'd0);

    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.in_valid  = cv[i].in_valid;
      bus.out_ready = cv[i].out_ready;
      #1;
      check($sformatf("comb%0d in_ready", i), bus.in_ready, cv[i].exp_in_ready);
      check($sformatf("comb%0d out_valid", i), bus.out_valid, cv[i].exp_out_valid);
    end
    // The accepted pixel above moved the position counter; start clean.
    do_reset();

    for (int i = 0; i < NFV; i++) begin
      run_frame(fv[i], $sformatf("f%0d", i));
    end

`ifdef BLUR_SCHED_STATS_EN
    check("stats frame_count", bus.frame_count, 16'd22);
    check("stats change_count", bus.change_count, 16'd7);
`else
    check("stats frame_count", bus.frame_count, 16'd0);
    check("stats change_count", bus.change_count, 16'd0);
`endif

    // Reset in the middle of a frame, then a clean frame starting at (0,0).
    for (int p = 0; p < 50; p++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_sop   = (p == 0);
      bus.in_eop   = 1'b0;
    end
    do_reset();
    #1;
    check("midrst freq_flag", bus.freq_flag, 3'b000);
    check("midrst frame_err", bus.frame_err, 1'b0);
    check("midrst priming", bus.priming, 1'b0);
    check("midrst frame_count", bus.frame_count, 16'd0);
    run_frame(post_rst, "post_rst");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/blur_kernel_scheduler.md
Name: blur_kernel_scheduler

Overview:
Controller that sequences `blurring_filter` kernel-size changes on a live 12-bit pixel stream. Kernel requests arrive asynchronously to the frame timing, for example from the audio/frequency control path. The block commits a request to `freq_flag` only at a frame boundary and enforces a minimum dwell time between changes. After each change it masks output valid until the filter's line buffers have re-primed.

Parameters:
- IMG_WIDTH, 320, pixels per line.
- IMG_HEIGHT, 240, lines per frame.
- DWELL_FRAMES, 2, minimum number of whole frames between kernel changes; legal range 1..15.
- MAX_FLAG, 3'b010, largest legal kernel code; requests above it are clamped.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  kernel request strobe.
- req_flag  in  3  requested kernel: 000 = 1x1, 001 = 3x3, 010 = 5x5.
- in_valid  in  1  upstream pixel valid.
- in_sop  in  1  first pixel of frame; qualified by in_valid & in_ready.
- in_eop  in  1  last pixel of frame; qualified by in_valid & in_ready.
- out_ready  in  1  downstream ready.
- in_ready  out  1  equals out_ready (combinational pass-through).
- out_valid  out  1  equals in_valid & ~priming (combinational).
- freq_flag  out  3  registered kernel code driving `blurring_filter`.
- priming  out  1  registered; high while output is masked.
- change_pulse  out  1  one-cycle pulse in the cycle freq_flag takes a new value.
- frame_err  out  1  sticky framing error flag; cleared only by reset.
- frame_count  out  16  frame counter; active only with the optional feature.
- change_count  out  16  kernel-change counter; active only with the optional feature.

Behaviour:
- Reset values:
  - freq_flag = 000, pending = 000, priming = 0, change_pulse = 0, frame_err = 0.
  - Position counters x = 0, y = 0.
  - dwell_cnt = DWELL_FRAMES, so the dwell is already satisfied.
  - State = RUN.
  - Reset mid-frame aborts all activity; the next accepted pixel is treated as position (0,0).
- Accept: acc = in_valid & in_ready.
- Request capture:
  - On req_valid, pending <= min(req_flag, MAX_FLAG).
  - Latest request wins.
  - A request arriving in the same cycle as an accepted eop is not used at that boundary; it waits for the next boundary.
- Position tracking:
  - On acc, x increments; at IMG_WIDTH-1, x wraps to 0 and y increments.
  - An accepted sop forces position to (0,0) for that pixel.
  - An accepted eop resets the counters to 0 after that pixel.
  - sop with position ≠ (0,0), or eop with position ≠ (IMG_WIDTH-1, IMG_HEIGHT-1), sets frame_err. Processing continues.
- Frame boundary (acc & in_eop):
  - If dwell_cnt < DWELL_FRAMES, dwell_cnt increments (saturating).
  - If pending ≠ freq_flag and dwell_cnt ≥ DWELL_FRAMES (value before the increment): next cycle freq_flag <= pending, change_pulse = 1, dwell_cnt <= 0, state <= PRIME.
  - Priming count loads r*IMG_WIDTH + r, where r = radius(pending): 0, 1 or 2.
  - If that count is 0 (1x1 kernel), go directly to RUN and priming stays 0.
- FSM states:
  - RUN: priming = 0.
  - PRIME: priming = 1. prime_cnt decrements on each acc; when it reaches 0 on an acc, return to RUN next cycle.
  - PRIME persists across the next frame's sop. The parameter check requires the priming count < IMG_WIDTH*IMG_HEIGHT.
  - An eop arriving while in PRIME cannot trigger a change, because dwell ≥ 1.
- Backpressure: while out_ready = 0 nothing is accepted, and all counters hold.
- Latency: freq_flag changes 1 cycle after the accepted eop. out_valid has zero latency.

Optional Feature:
- Macro: BLUR_SCHED_STATS_EN.
- Defined:
  - frame_count increments on each accepted eop.
  - change_count increments on each change_pulse.
  - Both counters wrap at 16 bits and reset to 0.
- Undefined: both ports are driven constant 0 and no counter logic is built.

Decomposition:
- Package blur_pkg holds:
  - kernel_t enum: K1 = 3'b000, K3 = 3'b001, K5 = 3'b010.
  - Function kernel_radius(kernel_t).
  - sched_state_t enum {RUN, PRIME}.
  - Flag width constant FLAG_W = 3.
- One sub-module, frame_pos_counter: x/y tracking with sop/eop resync; outputs last_pixel and err.
- FSM, dwell logic and priming logic stay at top level.

Test Plan (IMG_WIDTH = IMG_HEIGHT = 15, DWELL_FRAMES = 2):
- Reset check: reset pulse → freq_flag = 000, priming = 0, frame_err = 0; out_valid follows in_valid.
- Basic change:
  - Stimulus: req 010 mid-frame 0.
  - Response: freq_flag stays 000 until frame 0's eop is accepted. One cycle later freq_flag = 010 and change_pulse = 1 for exactly one cycle.
  - Then out_valid = 0 for the next 32 accepted pixels and 1 from the 33rd.
- Dwell enforcement:
  - Stimulus: req 001 immediately after the 5x5 change.
  - Response: no change at the end of frames 1 and 2; the change applies at the eop of frame 3.
  - Then 16 accepted pixels are masked.
- Clamp and request coincidence:
  - req 111 → pending = 010, so no change when freq_flag is already 010.
  - A req in the same cycle as eop is deferred to the next boundary.
- Backpressure:
  - Stimulus: out_ready = 0 for 10 cycles during PRIME.
  - Response: in_ready = 0, prime_cnt holds, and the masked-pixel total is still exactly 32.
- Framing error:
  - eop at pixel 100 → frame_err = 1 and stays set.
  - A subsequent sop resyncs the counters, and the flag change still occurs at that eop.
